// File: rtl/sd_pixel_pack.sv
// sd_pixel_pack: packs the SD reader byte stream into RGB565 words, buffers them in a
// first-word fall-through FIFO and hands them to the SDRAM writer over valid/ready.
// Tracks pixels per frame, pulses frame_done_o on the last pop, and keeps sticky
// overflow/misalignment flags.
// Optional build macro PACK_CHECKSUM_EN adds checksum_o, a running 16-bit sum of the
// words popped in the current frame.
module sd_pixel_pack #(
   parameter int unsigned FRAME_WORDS = 786432,
   parameter int unsigned FIFO_AW     = 4,
   parameter bit          HI_FIRST    = 1'b1
) (
   input  logic        SD_clk,
   input  logic        rst,
   input  logic        frame_start_i,
   input  logic [7:0]  byte_i,
   input  logic        byte_valid_i,
   input  logic        block_start_i,
   output logic [15:0] wr_data_o,
   output logic        wr_valid_o,
   input  logic        wr_ready_i,
   output logic        busy_o,
   output logic        frame_done_o,
   output logic        overflow_o,
   output logic        misalign_o
`ifdef PACK_CHECKSUM_EN
   ,
   output logic [15:0] checksum_o
`endif
);

   localparam int unsigned      Depth      = 2 ** FIFO_AW;
   localparam logic [FIFO_AW:0] DepthCnt   = (FIFO_AW + 1)'(Depth);
   localparam logic [19:0]      FrameWords = 20'(FRAME_WORDS);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e               state_q, state_d;
   logic [15:0]          mem_q [Depth];
   logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]     count_q, count_d;
   logic [19:0]          in_cnt_q, in_cnt_d;
   logic [19:0]          out_cnt_q, out_cnt_d;
   logic                 phase_q, phase_d;
   logic [7:0]           hold_q, hold_d;
   logic                 frame_done_q, frame_done_d;
   logic                 overflow_q, overflow_d;
   logic                 misalign_q, misalign_d;
`ifdef PACK_CHECKSUM_EN
   logic [15:0]          sum_q, sum_d;
`endif

   logic                 pop;
   logic                 push;
   logic                 push_ok;
   logic                 phase_eff;
   logic [15:0]          push_word;

   assign wr_valid_o   = (count_q != '0);
   // Empty FIFO presents zero so the bus is quiet after reset and flushes.
   assign wr_data_o    = wr_valid_o ? mem_q[rd_ptr_q] : 16'h0000;
   assign busy_o       = (state_q == StRun);
   assign frame_done_o = frame_done_q;
   assign overflow_o   = overflow_q;
   assign misalign_o   = misalign_q;
`ifdef PACK_CHECKSUM_EN
   assign checksum_o   = sum_q;
`endif

   // Next-state logic: frame control, byte packing, FIFO pointers and frame accounting.
   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      in_cnt_d     = in_cnt_q;
      out_cnt_d    = out_cnt_q;
      phase_d      = phase_q;
      hold_d       = hold_q;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;
      misalign_d   = misalign_q;
`ifdef PACK_CHECKSUM_EN
      sum_d        = sum_q;
`endif
      pop          = wr_valid_o && wr_ready_i;
      push         = 1'b0;
      push_ok      = 1'b0;
      phase_eff    = phase_q;
      push_word    = 16'h0000;

      if (frame_start_i) begin
         // New frame from any state: flush everything, bytes this cycle are ignored.
         state_d    = StRun;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         in_cnt_d   = '0;
         out_cnt_d  = '0;
         phase_d    = 1'b0;
         overflow_d = 1'b0;
         misalign_d = 1'b0;
`ifdef PACK_CHECKSUM_EN
         sum_d      = 16'h0000;
`endif
      end else begin
         if (state_q == StRun) begin
            // A block boundary with half a pixel pending drops the orphaned byte.
            if (block_start_i && phase_q) begin
               misalign_d = 1'b1;
               phase_eff  = 1'b0;
               phase_d    = 1'b0;
            end
            if (byte_valid_i && (in_cnt_q != FrameWords)) begin
               if (!phase_eff) begin
                  hold_d  = byte_i;
                  phase_d = 1'b1;
               end else begin
                  push      = 1'b1;
                  push_word = HI_FIRST ? {hold_q, byte_i} : {byte_i, hold_q};
                  phase_d   = 1'b0;
                  in_cnt_d  = in_cnt_q + 20'd1;
               end
            end
         end

         // A full FIFO still accepts a word when a pop frees a slot on the same edge.
         push_ok = push && ((count_q != DepthCnt) || pop);
         if (push && !push_ok) begin
            overflow_d = 1'b1;
         end
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end

         if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            out_cnt_d = out_cnt_q + 20'd1;
`ifdef PACK_CHECKSUM_EN
            sum_d     = sum_q + wr_data_o;
`endif
            if ((state_q == StRun) && ((out_cnt_q + 20'd1) == FrameWords)) begin
               state_d      = StDone;
               frame_done_d = 1'b1;
            end
         end

         count_d = count_q + {{FIFO_AW{1'b0}}, push_ok} - {{FIFO_AW{1'b0}}, pop};
      end
   end

   // State and control registers with synchronous reset.
   always_ff @(posedge SD_clk) begin
      if (rst) begin
         state_q      <= StIdle;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         in_cnt_q     <= '0;
         out_cnt_q    <= '0;
         phase_q      <= 1'b0;
         hold_q       <= 8'h00;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
         misalign_q   <= 1'b0;
`ifdef PACK_CHECKSUM_EN
         sum_q        <= 16'h0000;
`endif
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         in_cnt_q     <= in_cnt_d;
         out_cnt_q    <= out_cnt_d;
         phase_q      <= phase_d;
         hold_q       <= hold_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
         misalign_q   <= misalign_d;
`ifdef PACK_CHECKSUM_EN
         sum_q        <= sum_d;
`endif
      end
   end

   // FIFO storage; contents need no reset because count_q gates visibility.
   always_ff @(posedge SD_clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_word;
      end
   end

endmodule

// File: tb/tb_sd_pixel_pack.sv
// Scoreboard bench for sd_pixel_pack: a queue-based frame model predicts accepted words,
// a negedge monitor compares every pop and the status outputs. Two DUTs share stimulus,
// one per byte order.
module tb_sd_pixel_pack;

   localparam int FW    = 20;
   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fs  = 1'b0;
   logic [7:0]  b   = 8'h00;
   logic        bv  = 1'b0;
   logic        bs  = 1'b0;
   logic        rdy = 1'b0;

   logic [15:0] data_hi, data_lo;
   logic        valid_hi, valid_lo;
   logic        busy_hi, busy_lo, done_hi, done_lo;
   logic        ovf_hi, ovf_lo, mis_hi, mis_lo;
`ifdef PACK_CHECKSUM_EN
   logic [15:0] csum_hi, csum_lo;
`endif

   always #5 clk = ~clk;

   sd_pixel_pack #(.FRAME_WORDS(FW), .FIFO_AW(4), .HI_FIRST(1'b1)) u_hi (
      .SD_clk(clk), .rst(rst), .frame_start_i(fs), .byte_i(b), .byte_valid_i(bv),
      .block_start_i(bs), .wr_data_o(data_hi), .wr_valid_o(valid_hi), .wr_ready_i(rdy),
      .busy_o(busy_hi), .frame_done_o(done_hi), .overflow_o(ovf_hi), .misalign_o(mis_hi)
`ifdef PACK_CHECKSUM_EN
      , .checksum_o(csum_hi)
`endif
   );

   sd_pixel_pack #(.FRAME_WORDS(FW), .FIFO_AW(4), .HI_FIRST(1'b0)) u_lo (
      .SD_clk(clk), .rst(rst), .frame_start_i(fs), .byte_i(b), .byte_valid_i(bv),
      .block_start_i(bs), .wr_data_o(data_lo), .wr_valid_o(valid_lo), .wr_ready_i(rdy),
      .busy_o(busy_lo), .frame_done_o(done_lo), .overflow_o(ovf_lo), .misalign_o(mis_lo)
`ifdef PACK_CHECKSUM_EN
      , .checksum_o(csum_lo)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit mon_en  = 1'b0;

   // Reference model state (0 idle, 1 run, 2 done).
   int          mode = 0;
   bit          half = 1'b0;
   logic [7:0]  held = 8'h00;
   int          in_cnt = 0, out_cnt = 0;
   bit          ovf_e = 1'b0, mis_e = 1'b0, done_e = 1'b0;
   logic [15:0] sum_hi_e = 16'h0, sum_lo_e = 16'h0;
   logic [15:0] mf_hi[$], mf_lo[$];
   logic [15:0] exp_hi[$], exp_lo[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic flush_model();
      mf_hi.delete(); mf_lo.delete(); exp_hi.delete(); exp_lo.delete();
      half = 1'b0; in_cnt = 0; out_cnt = 0; ovf_e = 1'b0; mis_e = 1'b0;
      sum_hi_e = 16'h0; sum_lo_e = 16'h0;
   endtask

   // Applies the frame rules to the inputs present at this rising edge.
   task automatic model_step();
      bit pop, push;
      logic [15:0] w_hi, w_lo;
      done_e = 1'b0;
      if (rst) begin
         mode = 0;
         flush_model();
         return;
      end
      if (fs) begin
         mode = 1;
         flush_model();
         return;
      end
      pop  = (mf_hi.size() > 0) && rdy;
      push = 1'b0;
      w_hi = 16'h0;
      w_lo = 16'h0;
      if (mode == 1) begin
         if (bs && half) begin
            mis_e = 1'b1;
            half  = 1'b0;
         end
         if (bv && in_cnt < FW) begin
            if (!half) begin
               held = b;
               half = 1'b1;
            end else begin
               push = 1'b1;
               w_hi = {held, b};
               w_lo = {b, held};
               half = 1'b0;
               in_cnt++;
            end
         end
      end
      if (pop) begin
         sum_hi_e += mf_hi.pop_front();
         sum_lo_e += mf_lo.pop_front();
         out_cnt++;
         if (mode == 1 && out_cnt == FW) begin
            mode   = 2;
            done_e = 1'b1;
         end
      end
      if (push) begin
         if (mf_hi.size() < DEPTH) begin
            mf_hi.push_back(w_hi); mf_lo.push_back(w_lo);
            exp_hi.push_back(w_hi); exp_lo.push_back(w_lo);
         end else begin
            ovf_e = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic quiet();
      fs = 1'b0; bv = 1'b0; bs = 1'b0; rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] v, input logic blk);
      b = v; bv = 1'b1; bs = blk;
      tick();
      bv = 1'b0; bs = 1'b0;
   endtask

   task automatic start_frame();
      fs = 1'b1;
      tick();
      fs = 1'b0;
   endtask

   // Monitor: status outputs every cycle, pixel data on every handshake.
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            check("valid_hi", valid_hi, mf_hi.size() != 0);
            check("valid_lo", valid_lo, mf_lo.size() != 0);
            check("busy", busy_hi, mode == 1);
            check("frame_done", done_hi, done_e);
            check("overflow", ovf_hi, ovf_e);
            check("misalign", mis_hi, mis_e);
            check("frame_done_lo", done_lo, done_e);
`ifdef PACK_CHECKSUM_EN
            check("checksum_hi", csum_hi, sum_hi_e);
            check("checksum_lo", csum_lo, sum_lo_e);
`endif
            if (valid_hi && rdy) begin
               if (exp_hi.size() == 0) check("pop_unexpected_hi", 1, 0);
               else check("data_hi", data_hi, exp_hi.pop_front());
            end
            if (valid_lo && rdy) begin
               if (exp_lo.size() == 0) check("pop_unexpected_lo", 1, 0);
               else check("data_lo", data_lo, exp_lo.pop_front());
            end
         end
      end
   end

   initial begin
      logic [7:0] basic [8];
      basic = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};

      // Reset
      rst = 1'b1;
      tick();
      tick();
      quiet();
      mon_en = 1'b1;
      check("rst_data", data_hi, 16'h0);
      check("rst_valid", valid_hi, 1'b0);

      // Basic pack with a known head, finished with random pixels
      rdy = 1'b1;
      start_frame();
      for (int i = 0; i < 8; i++) send(basic[i], 1'b0);
      for (int i = 0; i < 2 * (FW - 4); i++) send(8'($urandom), 1'b0);
      for (int i = 0; i < 4; i++) tick();
      check("basic_done_state", busy_hi, 1'b0);

      // Misalign: AA dropped, 11/22 pair forms a word
      start_frame();
      check("restart_clears_ovf", ovf_hi, 1'b0);
      send(8'hAA, 1'b0);
      send(8'h11, 1'b1);
      send(8'h22, 1'b0);
      tick();
      check("misalign_set", mis_hi, 1'b1);

      // Backpressure and overflow: 40 bytes with ready low
      start_frame();
      rdy = 1'b0;
      for (int i = 0; i < 40; i++) send(8'($urandom), 1'b0);
      check("ovf_set", ovf_hi, 1'b1);
      rdy = 1'b1;
      for (int i = 0; i < 20; i++) tick();

      // Full boundary: fill to 16 then push while popping
      start_frame();
      rdy = 1'b0;
      for (int i = 0; i < 32; i++) send(8'($urandom), 1'b0);
      rdy = 1'b1;
      for (int i = 0; i < 8; i++) send(8'($urandom), 1'b0);
      check("full_no_ovf", ovf_hi, 1'b0);
      for (int i = 0; i < 20; i++) tick();

      // Reset with five words buffered
      start_frame();
      rdy = 1'b0;
      for (int i = 0; i < 10; i++) send(8'($urandom), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_mid_valid", valid_hi, 1'b0);
      check("rst_mid_data", data_hi, 16'h0);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rst = ($urandom_range(0, 999) == 0);
         if (mode != 1) fs = ($urandom_range(0, 9) == 0);
         else fs = ($urandom_range(0, 249) == 0);
         bv  = ($urandom_range(0, 9) < 7);
         b   = 8'($urandom);
         bs  = ($urandom_range(0, 39) == 0);
         rdy = ($urandom_range(0, 9) < 6);
         tick();
      end

      // Drain
      quiet();
      rdy = 1'b1;
      for (int i = 0; i < 40; i++) tick();
      check("drain_hi_empty", exp_hi.size(), 0);
      check("drain_lo_empty", exp_lo.size(), 0);

      mon_en = 1'b0;
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
